// File: rtl/pipe_mux_reg_if.sv
// Operand/select/handshake bundle for pipe_mux_reg.
// slave is the block's view; master is the driver's view.
interface pipe_mux_reg_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned N_IN  = 4
);
   localparam int unsigned SEL_W = $clog2(N_IN);

   logic [N_IN*WIDTH-1:0] mux_i;
   logic [SEL_W-1:0]      sel_i;
   logic                  valid_i;
   logic                  ready_o;
   logic                  flush_i;
   logic [WIDTH-1:0]      mux_o;
   logic                  valid_o;
   logic                  ready_i;

   modport slave (
      input  mux_i, sel_i, valid_i, flush_i, ready_i,
      output ready_o, mux_o, valid_o
   );

   modport master (
      output mux_i, sel_i, valid_i, flush_i, ready_i,
      input  ready_o, mux_o, valid_o
   );
endinterface

// File: rtl/pipe_mux_reg.sv
// N-way operand select captured into a registered valid/ready output stage
// with a 2-entry skid buffer so ready_o can be a flop.
module pipe_mux_reg #(
   parameter int unsigned     WIDTH   = 32,
   parameter int unsigned     N_IN    = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   pipe_mux_reg_if.slave  bus
);
   typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             ready_q, ready_d;
   logic [WIDTH-1:0] sel_data;
   logic             accept, pop;

   // Out-of-range selects fall through to RST_VAL.
   always_comb begin
      sel_data = RST_VAL;
      for (int unsigned k = 0; k < N_IN; k++) begin
         if (32'(bus.sel_i) == k) sel_data = bus.mux_i[k*WIDTH +: WIDTH];
      end
   end

   assign accept = bus.valid_i & ready_q;
   assign pop    = (state_q != StEmpty) & bus.ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StEmpty;
         main_q  <= RST_VAL;
         skid_q  <= RST_VAL;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         ready_q <= ready_d;
      end
   end

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
         StEmpty: begin
            if (accept) begin
               state_d = StOne;
               main_d  = sel_data;
            end
         end
         StOne: begin
            if (accept && pop) begin
               main_d = sel_data;
            end else if (accept) begin
               state_d = StFull;
               skid_d  = sel_data;
            end else if (pop) begin
               state_d = StEmpty;
            end
         end
         StFull: begin
            if (pop) begin
               state_d = StOne;
               main_d  = skid_q;
            end
         end
         default: state_d = StEmpty;
      endcase
      // Flush drops held and incoming items; main keeps its stale value.
      if (bus.flush_i) begin
         state_d = StEmpty;
         main_d  = main_q;
         skid_d  = skid_q;
      end
      ready_d = (state_d != StFull);
   end

   always_comb begin
      bus.valid_o = (state_q != StEmpty);
      bus.ready_o = ready_q;
      bus.mux_o   = main_q;
   end
endmodule

// File: tb/tb_pipe_mux_reg.sv
// Bench for pipe_mux_reg: directed vectors and sequences plus a randomized
// run scored against a queue model.
module tb_pipe_mux_reg;
   localparam logic [31:0] RST4 = 32'hCAFE_0000;
   localparam logic [7:0]  RST3 = 8'hA5;

   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk_i = ~clk_i;

   pipe_mux_reg_if #(.WIDTH(32), .N_IN(4)) bus4 ();
   pipe_mux_reg_if #(.WIDTH(8), .N_IN(3))  bus3 ();

   pipe_mux_reg #(.WIDTH(32), .N_IN(4), .RST_VAL(RST4)) dut4 (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .bus   (bus4.slave)
   );

   pipe_mux_reg #(.WIDTH(8), .N_IN(3), .RST_VAL(RST3)) dut3 (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .bus   (bus3.slave)
   );

   typedef struct {
      logic [1:0]  sel;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One active edge, then return at the following negedge.
   task automatic cyc();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic fill_full4(input logic [31:0] a, input logic [31:0] b);
      bus4.sel_i   = 2'd0;
      bus4.ready_i = 1'b0;
      bus4.valid_i = 1'b1;
      bus4.mux_i[31:0] = a;
      cyc();
      bus4.mux_i[31:0] = b;
      cyc();
      bus4.valid_i = 1'b0;
   endtask

   logic [31:0] q[$];
   logic        ready_m;
   logic [31:0] ops[4];
   int          streamed;

   initial begin
      bus4.mux_i = '0; bus4.sel_i = '0; bus4.valid_i = 0; bus4.flush_i = 0; bus4.ready_i = 0;
      bus3.mux_i = '0; bus3.sel_i = '0; bus3.valid_i = 0; bus3.flush_i = 0; bus3.ready_i = 0;
      for (int i = 0; i < 4; i++) begin
         vecs[i].sel = 2'(i);
         vecs[i].exp = 32'h11 * 32'(i + 1);
      end
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;

      check("reset valid_o", 32'(bus4.valid_o), 32'd0);
      check("reset ready_o", 32'(bus4.ready_o), 32'd1);
      check("reset mux_o", bus4.mux_o, RST4);
      check("reset mux_o n3", 32'(bus3.mux_o), 32'(RST3));

      // Select table, one item per cycle with 1-cycle latency.
      bus4.mux_i   = {32'h44, 32'h33, 32'h22, 32'h11};
      bus4.valid_i = 1'b1;
      bus4.ready_i = 1'b1;
      foreach (vecs[i]) begin
         bus4.sel_i = vecs[i].sel;
         cyc();
         check($sformatf("select %0d", i), bus4.mux_o, vecs[i].exp);
         check($sformatf("select %0d valid", i), 32'(bus4.valid_o), 32'd1);
      end
      bus4.valid_i = 1'b0;
      cyc();
      check("drain valid_o", 32'(bus4.valid_o), 32'd0);
      check("empty holds mux_o", bus4.mux_o, 32'h44);

      // Out-of-range select on the 3-way instance.
      bus3.mux_i   = {8'h33, 8'h22, 8'h11};
      bus3.sel_i   = 2'd3;
      bus3.valid_i = 1'b1;
      bus3.ready_i = 1'b1;
      cyc();
      check("oor mux_o", 32'(bus3.mux_o), 32'(RST3));
      check("oor valid_o", 32'(bus3.valid_o), 32'd1);
      bus3.sel_i = 2'd2;
      cyc();
      check("n3 sel2 mux_o", 32'(bus3.mux_o), 32'h33);
      bus3.valid_i = 1'b0;

      // Backpressure: A, B taken, C held off, then in-order drain.
      bus4.sel_i   = 2'd0;
      bus4.ready_i = 1'b0;
      bus4.valid_i = 1'b1;
      bus4.mux_i[31:0] = 32'hA000_000A;
      cyc();
      check("bp A mux_o", bus4.mux_o, 32'hA000_000A);
      check("bp one ready_o", 32'(bus4.ready_o), 32'd1);
      bus4.mux_i[31:0] = 32'hB000_000B;
      cyc();
      check("bp full ready_o", 32'(bus4.ready_o), 32'd0);
      check("bp full mux_o", bus4.mux_o, 32'hA000_000A);
      bus4.mux_i[31:0] = 32'hC000_000C;
      cyc();
      check("bp hold mux_o", bus4.mux_o, 32'hA000_000A);
      check("bp hold valid_o", 32'(bus4.valid_o), 32'd1);
      check("bp hold ready_o", 32'(bus4.ready_o), 32'd0);
      bus4.ready_i = 1'b1;
      cyc();
      check("bp deliver B", bus4.mux_o, 32'hB000_000B);
      check("bp reopen ready_o", 32'(bus4.ready_o), 32'd1);
      cyc();
      check("bp deliver C", bus4.mux_o, 32'hC000_000C);
      check("bp C valid_o", 32'(bus4.valid_o), 32'd1);
      bus4.valid_i = 1'b0;
      cyc();
      check("bp drained", 32'(bus4.valid_o), 32'd0);

      // Flush while full with an incoming item and a pop offered.
      fill_full4(32'h1111_0001, 32'h2222_0002);
      check("pre-flush ready_o", 32'(bus4.ready_o), 32'd0);
      bus4.valid_i = 1'b1;
      bus4.mux_i[31:0] = 32'h3333_0003;
      bus4.flush_i = 1'b1;
      bus4.ready_i = 1'b1;
      cyc();
      check("flush valid_o", 32'(bus4.valid_o), 32'd0);
      check("flush ready_o", 32'(bus4.ready_o), 32'd1);
      bus4.flush_i = 1'b0;
      bus4.valid_i = 1'b0;
      repeat (3) begin
         cyc();
         check("post-flush valid_o", 32'(bus4.valid_o), 32'd0);
      end

      // Asynchronous reset while full, checked before any edge.
      fill_full4(32'h5555_0005, 32'h6666_0006);
      #2 rst_ni = 1'b0;
      #1;
      check("async rst valid_o", 32'(bus4.valid_o), 32'd0);
      check("async rst ready_o", 32'(bus4.ready_o), 32'd1);
      check("async rst mux_o", bus4.mux_o, RST4);
      @(negedge clk_i);
      rst_ni = 1'b1;
      cyc();
      check("restart valid_o", 32'(bus4.valid_o), 32'd0);

      // Randomized run against a queue model.
      q.delete();
      ready_m  = 1'b1;
      streamed = 0;
      for (int n = 0; n < 10000; n++) begin
         logic vld, rdy, fl, acc, pp;
         logic [1:0] sel;
         if (n < 200) begin
            vld = 1'b1; rdy = 1'b1; fl = 1'b0;
         end else begin
            vld = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            fl  = ($urandom_range(0, 40) == 0);
         end
         sel = 2'($urandom_range(0, 3));
         for (int k = 0; k < 4; k++) ops[k] = $urandom;
         bus4.mux_i   = {ops[3], ops[2], ops[1], ops[0]};
         bus4.sel_i   = sel;
         bus4.valid_i = vld;
         bus4.ready_i = rdy;
         bus4.flush_i = fl;
         acc = vld & ready_m;
         pp  = (q.size() > 0) & rdy;
         if (fl) begin
            q.delete();
         end else begin
            if (pp) void'(q.pop_front());
            if (acc) q.push_back(ops[sel]);
         end
         ready_m = (q.size() < 2);
         cyc();
         if (n < 200 && bus4.valid_o) streamed++;
         check("rand valid_o", 32'(bus4.valid_o), 32'(q.size() > 0));
         check("rand ready_o", 32'(bus4.ready_o), 32'(ready_m));
         if (q.size() > 0) check("rand mux_o", bus4.mux_o, q[0]);
      end
      check("streaming throughput", 32'(streamed), 32'd200);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
